// File: rtl/census_row_encoder.sv
// Streaming 1-D census transform over a WIDTH+1 pixel sliding window.
// Emits one WIDTH-bit signature per centre pixel once a line has filled the window.
module census_row_encoder #(
  parameter int PIXEL_WIDTH = 8,
  parameter int WIDTH       = 32,
  parameter int COL_WIDTH   = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  input  logic                   in_sol,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_census,
  output logic [COL_WIDTH-1:0]   out_col
);

  // Stream semantics: a pixel is consumed on every rising edge with in_valid=1
  // (no backpressure); out_valid marks a one-cycle result, out_census/out_col
  // hold their last values whenever out_valid=0.

  localparam int HALF   = WIDTH / 2;
  localparam int FILL_W = $clog2(WIDTH + 2);
  localparam logic [FILL_W-1:0]    FULL    = FILL_W'(WIDTH + 1);
  localparam logic [COL_WIDTH-1:0] HALF_CV = COL_WIDTH'(HALF);

  logic [PIXEL_WIDTH-1:0] win      [0:WIDTH];
  logic [PIXEL_WIDTH-1:0] win_next [0:WIDTH];
  logic [PIXEL_WIDTH-1:0] centre;
  logic [WIDTH-1:0]       census_next;
  logic [FILL_W-1:0]      fill, fill_next;
  logic [COL_WIDTH-1:0]   col, col_next;

  always_comb begin
    win_next[0] = in_pixel;
    for (int i = 1; i <= WIDTH; i++) begin
      win_next[i] = win[i-1];
    end
  end

  assign centre = win_next[HALF];

  // Newer half maps straight to the low bits; the older half skips over the centre slot.
  always_comb begin
    census_next = '0;
    for (int j = 0; j < HALF; j++) begin
      census_next[j] = (win_next[j] < centre);
    end
    for (int j = HALF; j < WIDTH; j++) begin
      census_next[j] = (win_next[j+1] < centre);
    end
  end

  always_comb begin
    fill_next = fill;
    col_next  = col;
    if (in_sol) begin
      fill_next = FILL_W'(1);
      col_next  = '0;
    end else begin
      if (fill != FULL) fill_next = fill + FILL_W'(1);
      col_next = col + COL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= WIDTH; i++) begin
        win[i] <= '0;
      end
      fill       <= '0;
      col        <= '0;
      out_valid  <= 1'b0;
      out_census <= '0;
      out_col    <= '0;
    end else if (in_valid) begin
      for (int i = 0; i <= WIDTH; i++) begin
        win[i] <= win_next[i];
      end
      fill      <= fill_next;
      col       <= col_next;
      out_valid <= (fill_next == FULL);
      if (fill_next == FULL) begin
        out_census <= census_next;
        out_col    <= col_next - HALF_CV;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_census_row_encoder.sv
// Directed and random checks for census_row_encoder at WIDTH=32, PIXEL_WIDTH=8.
module tb_census_row_encoder;

  localparam int PW = 8;
  localparam int W  = 32;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic          in_sol = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_census;
  logic [CW-1:0] out_col;

  int n_cmp = 0;
  int n_err = 0;

  census_row_encoder #(.PIXEL_WIDTH(PW), .WIDTH(W), .COL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel), .in_sol(in_sol),
    .out_valid(out_valid), .out_census(out_census), .out_col(out_col)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic push(input logic [PW-1:0] p, input logic sol);
    in_valid = 1'b1;
    in_pixel = p;
    in_sol   = sol;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
  endtask

  task automatic idle(input logic sol);
    in_valid = 1'b0;
    in_sol   = sol;
    in_pixel = 8'hA5;
    @(posedge clk);
    #1;
    in_sol = 1'b0;
  endtask

  logic [PW-1:0] mq[$];
  int            mcol;
  logic [W-1:0]  exp_c;
  logic          seen;
  int            nout;
  logic          v, s;
  logic [PW-1:0] p;

  initial begin
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_census", out_census, 0);
    check("rst_col", out_col, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: rising ramp
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      push(8'(i), i == 0);
      seen |= out_valid;
    end
    check("t1_early_valid", seen, 0);
    push(8'd32, 1'b0);
    check("t1_valid", out_valid, 1);
    check("t1_census", out_census, 32'hFFFF0000);
    check("t1_col", out_col, 16);

    // 2A: falling ramp
    for (int i = 32; i >= 0; i--) push(8'(i), i == 32);
    check("t2a_valid", out_valid, 1);
    check("t2a_census", out_census, 32'h0000FFFF);
    check("t2a_col", out_col, 16);

    // 2B: flat line
    seen = 1'b0;
    nout = 0;
    for (int i = 0; i < 40; i++) begin
      push(8'h55, i == 0);
      if (i < 32) seen |= out_valid;
      else begin
        check("t2b_valid", out_valid, 1);
        check("t2b_census", out_census, 0);
        check("t2b_col", out_col, 64'(16 + i - 32));
      end
      if (out_valid) nout++;
    end
    check("t2b_early_valid", seen, 0);
    check("t2b_count", nout, 8);

    // 3: ramp with a bubble after every pixel
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      push(8'(i), i == 0);
      idle(1'b0);
      seen |= out_valid;
    end
    push(8'd32, 1'b0);
    check("t3_valid", out_valid, 1);
    check("t3_census", out_census, 32'hFFFF0000);
    check("t3_col", out_col, 16);
    idle(1'b0);
    check("t3_bubble_valid", seen | out_valid, 0);
    check("t3_hold_census", out_census, 32'hFFFF0000);
    check("t3_hold_col", out_col, 16);

    // 4: mid-line SOL, then SOL on a window-completing pixel
    for (int i = 0; i < 40; i++) push(8'(i * 7), i == 0);
    check("t4_pre_valid", out_valid, 1);
    check("t4_pre_col", out_col, 23);
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      push(8'(i), i == 0);
      seen |= out_valid;
    end
    check("t4_gap_valid", seen, 0);
    push(8'd32, 1'b0);
    check("t4_valid", out_valid, 1);
    check("t4_col", out_col, 16);
    check("t4_census", out_census, 32'hFFFF0000);
    for (int i = 0; i < 32; i++) push(8'(i), i == 0);
    push(8'd32, 1'b1);
    check("t4_sol_wins", out_valid, 0);

    // 5: async reset while out_valid=1
    for (int i = 0; i < 33; i++) push(8'(i), i == 0);
    check("t5_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_census", out_census, 0);
    check("t5_rst_col", out_col, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      push(8'(i), 1'b0);
      seen |= out_valid;
    end
    check("t5_refill_valid", seen, 0);
    push(8'd32, 1'b0);
    check("t5_valid", out_valid, 1);
    check("t5_census", out_census, 32'hFFFF0000);

    // 6: random stream against a line-history model
    mq.delete();
    mcol = 0;
    for (int c = 0; c < 1000; c++) begin
      v = (c == 0) || ($urandom_range(0, 4) != 0);
      s = (c == 0) || ($urandom_range(0, 59) == 0);
      p = 8'($urandom_range(0, 255));
      if (v) push(p, s);
      else idle(s);
      if (v) begin
        if (s) begin
          mq.delete();
          mcol = 0;
        end else mcol++;
        mq.push_back(p);
        if (mq.size() > 33) void'(mq.pop_front());
      end
      check("t6_valid", out_valid, 64'(v && mq.size() == 33));
      if (v && mq.size() == 33) begin
        exp_c = '0;
        for (int k = 0; k < 33; k++) begin
          if (k < 16) exp_c[31-k] = (mq[k] < mq[16]);
          else if (k > 16) exp_c[32-k] = (mq[k] < mq[16]);
        end
        check("t6_census", out_census, exp_c);
        check("t6_pop", $countones(out_census ^ exp_c), 0);
        check("t6_col", out_col, 64'((mcol - 16) & 32'h7FF));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
